// File: rtl/ps2_key_event_ctrl_if.sv
// Bus between the PS/2 key-event sequencer and its environment: receiver strobes in,
// CPU-side event FIFO handshake and status out.
interface ps2_key_event_ctrl_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    rx_byte;
   logic          rx_valid;
   logic          rx_err;
   logic [9:0]    evt_data;
   logic          evt_valid;
   logic          evt_ready;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic          seq_err;
   logic          clr_flags;

   modport master (
      output rx_byte, rx_valid, rx_err, evt_ready, clr_flags,
      input  evt_data, evt_valid, fifo_count, overflow, seq_err
   );

   modport slave (
      input  rx_byte, rx_valid, rx_err, evt_ready, clr_flags,
      output evt_data, evt_valid, fifo_count, overflow, seq_err
   );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into {ext, brk, code} events and
// queues them in a first-word-fall-through FIFO drained by the CPU.
module ps2_key_event_ctrl #(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ps2_key_event_ctrl_if.slave   bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [TW-1:0]   r_tmo;
   logic [9:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic            r_overflow;
   logic            r_seq_err;

   logic            w_byte;
   logic            w_bad;
   logic            w_prefix;
   logic            w_timeout;
   logic            w_push;
   logic            w_seq_set;
   logic [9:0]      w_evt;
   logic            w_full;
   logic            w_pop;
   logic            w_wr;
   logic            w_ovf_set;

   function automatic logic is_bad_code(input logic [7:0] b);
      return (b == 8'h00) || (b == 8'hFF);
   endfunction

   // Prefix decoder: next state, event push and sequence-error detection
   always_comb begin
      w_byte      = bus.rx_valid && !bus.rx_err;
      w_bad       = is_bad_code(bus.rx_byte);
      w_prefix    = (bus.rx_byte == 8'hE0) || (bus.rx_byte == 8'hF0);
      w_timeout   = (r_state != S_IDLE) && (r_tmo == TW'(TIMEOUT_CYC - 1));
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_seq_set   = 1'b0;
      w_evt       = {2'b00, bus.rx_byte};
      if (bus.rx_err) begin
         w_state_nxt = S_IDLE;
         w_seq_set   = (r_state != S_IDLE);
      end else if (w_byte) begin
         case (r_state)
            S_IDLE: begin
               if (bus.rx_byte == 8'hE0) begin
                  w_state_nxt = S_EXT;
               end else if (bus.rx_byte == 8'hF0) begin
                  w_state_nxt = S_BRK;
               end else if (w_bad) begin
                  w_seq_set = 1'b1;
               end else begin
                  w_push = 1'b1;
               end
            end
            S_EXT: begin
               if (bus.rx_byte == 8'hF0) begin
                  w_state_nxt = S_EXT_BRK;
               end else if (bus.rx_byte == 8'hE0) begin
                  w_state_nxt = S_EXT;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_seq_set   = w_bad;
                  w_push      = !w_bad;
                  w_evt       = {2'b10, bus.rx_byte};
               end
            end
            S_BRK, S_EXT_BRK: begin
               w_state_nxt = S_IDLE;
               w_seq_set   = w_bad || w_prefix;
               w_push      = !(w_bad || w_prefix);
               w_evt       = {(r_state == S_EXT_BRK), 1'b1, bus.rx_byte};
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end else if (w_timeout) begin
         w_state_nxt = S_IDLE;
         w_seq_set   = 1'b1;
      end else begin
         w_state_nxt = r_state;
      end
   end

   // FIFO write/read qualification; a pop frees the slot a full-FIFO push needs
   always_comb begin
      w_full    = (r_count == CW'(FIFO_DEPTH));
      w_pop     = (r_count != {CW{1'b0}}) && bus.evt_ready;
      w_wr      = w_push && (!w_full || w_pop);
      w_ovf_set = w_push && w_full && !w_pop;
   end

   // Sequencer state and inter-byte timeout counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_tmo   <= {TW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         if ((w_state_nxt == S_IDLE) || w_byte) begin
            r_tmo <= {TW{1'b0}};
         end else begin
            r_tmo <= r_tmo + TW'(1);
         end
      end
   end

   // Event FIFO storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= 10'd0;
         end
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_count <= {CW{1'b0}};
      end else begin
         if (w_wr) begin
            r_mem[r_wptr] <= w_evt;
            r_wptr        <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      end
   end

   // Sticky flags; a new set event beats a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
         r_seq_err  <= 1'b0;
      end else begin
         r_overflow <= w_ovf_set || (r_overflow && !bus.clr_flags);
         r_seq_err  <= w_seq_set || (r_seq_err && !bus.clr_flags);
      end
   end

   assign bus.evt_valid  = (r_count != {CW{1'b0}});
   assign bus.evt_data   = bus.evt_valid ? r_mem[r_rptr] : 10'd0;
   assign bus.fifo_count = r_count;
   assign bus.overflow   = r_overflow;
   assign bus.seq_err    = r_seq_err;
endmodule
